prescaler_multi: RTL and testbench

//  Parametrised multi-channel clock prescaler. Generates CH independent divided

---
 rtl/prescaler_multi.sv | 114 +++++++++++
 tb/tb_prescaler_multi.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_multi.sv
// Multi-channel clock prescaler: CH divided square waves plus one-cycle tick strobes.
// Define PRESCALER_SYNC_EN to add the sync_in input that restarts every channel in phase.
module prescaler_multi #(
    parameter int unsigned CH      = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned DIV_RST = 49_999_999
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [CH-1:0]    enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef PRESCALER_SYNC_EN
    input  logic             sync_in,
`endif
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    logic [CNT_W-1:0] cnt_q    [CH];
    logic [CNT_W-1:0] cnt_d    [CH];
    logic [CNT_W-1:0] active_q [CH];
    logic [CNT_W-1:0] active_d [CH];
    logic [CNT_W-1:0] shadow_q [CH];
    logic [CNT_W-1:0] shadow_d [CH];
    logic [CH-1:0]    pending_q, pending_d;
    logic [CH-1:0]    clk_q, clk_d;
    logic [CH-1:0]    tick_q, tick_d;
    logic             sync_req;
    logic             accept;

`ifdef PRESCALER_SYNC_EN
    assign sync_req = sync_in;
`else
    assign sync_req = 1'b0;
`endif

    // Out-of-range channels are always ready so their writes drain and get dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if ((32'(cfg_ch) == c) && pending_q[c]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            cnt_d[c]     = cnt_q[c];
            active_d[c]  = active_q[c];
            shadow_d[c]  = shadow_q[c];
            pending_d[c] = pending_q[c];
            clk_d[c]     = clk_q[c];
            tick_d[c]    = 1'b0;

            if (sync_req || !enable[c]) begin
                cnt_d[c] = '0;
                clk_d[c] = 1'b0;
                if (pending_q[c]) begin
                    active_d[c]  = shadow_q[c];
                    pending_d[c] = 1'b0;
                end
            end else if (cnt_q[c] == active_q[c]) begin
                // Divisor swaps only here, at the period boundary, so clk_out never glitches.
                cnt_d[c]  = '0;
                clk_d[c]  = ~clk_q[c];
                tick_d[c] = 1'b1;
                if (pending_q[c]) begin
                    active_d[c]  = shadow_q[c];
                    pending_d[c] = 1'b0;
                end
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            if (accept && (32'(cfg_ch) == c)) begin
                shadow_d[c]  = cfg_div;
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                cnt_q[c]    <= '0;
                active_q[c] <= CNT_W'(DIV_RST);
                shadow_q[c] <= CNT_W'(DIV_RST);
            end
            pending_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                cnt_q[c]    <= cnt_d[c];
                active_q[c] <= active_d[c];
                shadow_q[c] <= shadow_d[c];
            end
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_prescaler_multi.sv
// Self-checking bench for prescaler_multi against an event-scheduled reference model.
// Exercises sync_in only when PRESCALER_SYNC_EN is defined.
module tb_prescaler_multi;
    localparam int CH      = 4;
    localparam int CH_W    = 3;
    localparam int CNT_W   = 8;
    localparam int DIV_RST = 3;

    logic             clk_in    = 1'b0;
    logic             reset     = 1'b0;
    logic [CH-1:0]    enable    = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch    = '0;
    logic [CNT_W-1:0] cfg_div   = '0;
    logic             sync_in   = 1'b0;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    prescaler_multi #(
        .CH     (CH),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
`ifdef PRESCALER_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk_out),
        .tick     (tick)
    );

    // Reference model: each channel schedules the absolute edge number of its next wrap.
    int            m_next    [CH];
    int            m_div     [CH];
    int            m_shadow  [CH];
    logic          m_pend    [CH];
    logic          m_restart [CH];
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_tick;
    int            edge_n;

    function automatic logic exp_ready();
        int idx;
        idx = int'(cfg_ch);
        if (idx >= CH) return 1'b1;
        return !m_pend[idx];
    endfunction

    always @(posedge clk_in or posedge reset) begin : model
        int   nxt, dv, sh;
        logic pd, rs, o, t, acc;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_next[c]    <= 0;
                m_div[c]     <= DIV_RST;
                m_shadow[c]  <= DIV_RST;
                m_pend[c]    <= 1'b0;
                m_restart[c] <= 1'b1;
            end
            m_out  <= '0;
            m_tick <= '0;
            edge_n <= 0;
        end else begin
            acc = cfg_valid && exp_ready() && (int'(cfg_ch) < CH);
            for (int c = 0; c < CH; c++) begin
                nxt = m_next[c];
                dv  = m_div[c];
                sh  = m_shadow[c];
                pd  = m_pend[c];
                rs  = m_restart[c];
                o   = m_out[c];
                t   = 1'b0;
                if (sync_in || !enable[c]) begin
                    o  = 1'b0;
                    rs = 1'b1;
                    if (pd) begin
                        dv = sh;
                        pd = 1'b0;
                    end
                end else begin
                    if (rs) begin
                        nxt = edge_n + dv;
                        rs  = 1'b0;
                    end
                    if (edge_n == nxt) begin
                        o = ~o;
                        t = 1'b1;
                        if (pd) begin
                            dv = sh;
                            pd = 1'b0;
                        end
                        nxt = edge_n + 1 + dv;
                    end
                end
                if (acc && (int'(cfg_ch) == c)) begin
                    sh = int'(cfg_div);
                    pd = 1'b1;
                end
                m_next[c]    <= nxt;
                m_div[c]     <= dv;
                m_shadow[c]  <= sh;
                m_pend[c]    <= pd;
                m_restart[c] <= rs;
                m_out[c]     <= o;
                m_tick[c]    <= t;
            end
            edge_n <= edge_n + 1;
        end
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++;
        if (clk_out !== '0) begin bad++; $display("FAIL reset clk_out got=%b exp=0", clk_out); end
        total++;
        if (tick !== '0) begin bad++; $display("FAIL reset tick got=%b exp=0", tick); end
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset cfg_ready got=%b exp=1", cfg_ready); end
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL reset_idle out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
        end
    endtask

    task automatic test_single();
        int first = 0;
        int cnt   = 0;
        enable = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL single out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            if (tick[0]) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        total++;
        if (first != 4) begin bad++; $display("FAIL single first_tick got=%0d exp=4", first); end
        total++;
        if (cnt != 4) begin bad++; $display("FAIL single tick_count got=%0d exp=4", cnt); end
    endtask

    task automatic test_cfg_midperiod();
        int first = 0;
        int cnt   = 0;
        repeat (2) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL cfg_pre out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_stall cfg_ready got=%b exp=0", cfg_ready); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL cfg out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            #1;
            total++;
            if (cfg_ready !== exp_ready()) begin
                bad++;
                $display("FAIL cfg ready got=%b exp=%b", cfg_ready, exp_ready());
            end
            if (tick[0]) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        total++;
        if (first != 1) begin bad++; $display("FAIL cfg first_tick got=%0d exp=1", first); end
        total++;
        if (cnt != 6) begin bad++; $display("FAIL cfg tick_count got=%0d exp=6", cnt); end
    endtask

    task automatic test_div0_oob();
        int ones = 0;
        @(negedge clk_in);
        enable    = 4'b0011;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 8'd0;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL div0 out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
        end
        cfg_valid = 1'b1;
        cfg_ch    = 3'd5;
        cfg_div   = 8'd7;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL oob cfg_ready got=%b exp=1", cfg_ready); end
        @(negedge clk_in);
        cfg_valid = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL oob out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            if (tick[1]) ones++;
        end
        total++;
        if (ones != 8) begin bad++; $display("FAIL div0 tick1_high got=%0d exp=8", ones); end
    endtask

    task automatic test_reenable();
        int first = 0;
        int cnt   = 0;
        enable    = 4'b0010;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd3;
        repeat (3) begin
            @(negedge clk_in);
            cfg_valid = 1'b0;
            total++;
            if ({clk_out[0], tick[0]} !== 2'b00) begin
                bad++;
                $display("FAIL disabled ch0 got=%b_%b exp=0_0", clk_out[0], tick[0]);
            end
        end
        enable = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL reenable out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            if (tick[0]) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        total++;
        if (first != 4) begin bad++; $display("FAIL reenable first_tick got=%0d exp=4", first); end
        total++;
        if (cnt != 2) begin bad++; $display("FAIL reenable tick_count got=%0d exp=2", cnt); end
    endtask

    task automatic test_async_reset();
        int first = 0;
        int cnt   = 0;
        @(negedge clk_in);
        @(negedge clk_in);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd5;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL arst_pending cfg_ready got=%b exp=0", cfg_ready); end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({clk_out, tick} !== '0) begin
            bad++;
            $display("FAIL arst out/tick got=%b_%b exp=0_0", clk_out, tick);
        end
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL arst cfg_ready got=%b exp=1", cfg_ready); end
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL arst_run out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            if (tick[0]) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        total++;
        if (first != 4) begin bad++; $display("FAIL arst first_tick got=%0d exp=4", first); end
        total++;
        if (cnt != 2) begin bad++; $display("FAIL arst tick_count got=%0d exp=2", cnt); end
    endtask

`ifdef PRESCALER_SYNC_EN
    task automatic test_sync();
        int first0 = 0;
        int first1 = 0;
        enable    = 4'b0011;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 8'd5;
        repeat (8) begin
            @(negedge clk_in);
            cfg_valid = 1'b0;
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL sync_pre out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
        end
        sync_in = 1'b1;
        @(negedge clk_in);
        sync_in = 1'b0;
        total++;
        if ({clk_out, tick} !== '0) begin
            bad++;
            $display("FAIL sync out/tick got=%b_%b exp=0_0", clk_out, tick);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL sync_run out/tick got=%b_%b exp=%b_%b", clk_out, tick, m_out, m_tick);
            end
            if (tick[0] && first0 == 0) first0 = k;
            if (tick[1] && first1 == 0) first1 = k;
        end
        total++;
        if (first0 != 4) begin bad++; $display("FAIL sync first_tick0 got=%0d exp=4", first0); end
        total++;
        if (first1 != 6) begin bad++; $display("FAIL sync first_tick1 got=%0d exp=6", first1); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_in);
            total++;
            if ({clk_out, tick} !== {m_out, m_tick}) begin
                bad++;
                $display("FAIL random out/tick cyc=%0d got=%b_%b exp=%b_%b",
                         i, clk_out, tick, m_out, m_tick);
            end
            if ($urandom_range(0, 15) == 0) enable = CH'($urandom_range(0, 15));
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = CNT_W'($urandom_range(0, 5));
`ifdef PRESCALER_SYNC_EN
            sync_in   = ($urandom_range(0, 39) == 0);
`endif
            #1;
            total++;
            if (cfg_ready !== exp_ready()) begin
                bad++;
                $display("FAIL random ready cyc=%0d got=%b exp=%b", i, cfg_ready, exp_ready());
            end
        end
        cfg_valid = 1'b0;
        sync_in   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_cfg_midperiod();
        test_div0_oob();
        test_reenable();
        test_async_reset();
`ifdef PRESCALER_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
